// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding,
// frame field sizes and a helper for spotting the last byte of a field.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
      S_SUM  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam int LEN_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   function automatic logic is_last_byte(input logic [1:0] idx, input logic len_phase);
      return idx == (len_phase ? 2'(LEN_BYTES - 1) : 2'(WORD_BYTES - 1));
   endfunction

endpackage

// File: rtl/uart_loader_asm.sv
// Byte-to-word assembler: packs bytes LSB first into a 32-bit word and keeps
// the running 8-bit wrapping checksum of every byte it accepts.
module uart_loader_asm
   import uart_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic        len_phase_i,
   input  logic [7:0]  byte_i,
   output logic        word_ready_o,
   output logic [31:0] word_o,
   output logic [7:0]  csum_o
);

   logic [1:0]  idx_q;
   logic [23:0] asm_q;
   logic [7:0]  csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= 2'd0;
         asm_q  <= 24'd0;
         csum_q <= 8'd0;
      end else if (clear_i) begin
         idx_q  <= 2'd0;
         asm_q  <= 24'd0;
         csum_q <= 8'd0;
      end else if (byte_valid_i) begin
         case (idx_q)
            2'd0:    asm_q[7:0]   <= byte_i;
            2'd1:    asm_q[15:8]  <= byte_i;
            2'd2:    asm_q[23:16] <= byte_i;
            default: ;
         endcase
         idx_q  <= idx_q + 2'd1;
         csum_q <= csum_q + byte_i;
      end
   end

   // The top byte is never stored: the word is complete while it is on the bus.
   assign word_ready_o = byte_valid_i && is_last_byte(idx_q, len_phase_i);
   assign word_o       = {byte_i, asm_q};
   assign csum_o       = csum_q;

endmodule

// File: rtl/uart_loader.sv
// Program image loader: parses length / words / checksum from the UART byte
// stream, writes the words to imem and releases the core on a clean load.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ack_o,
   input  logic              restart_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              load_busy_o,
   output logic              load_done_o,
   output logic              load_err_o,
   output logic              cpu_rst_n_o
);

   localparam int                CNT_W     = ADDR_W + 1;
   localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   state_t            state_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  word_cnt_q;
   logic              rx_ack_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;
   logic              load_busy_q;
   logic              load_done_q;
   logic              load_err_q;
   logic              cpu_rst_n_q;

   logic        asm_valid;
   logic        word_ready;
   logic [31:0] word;
   logic [7:0]  csum;

   assign asm_valid = rx_valid_i && !restart_i && (state_q == S_LEN || state_q == S_DATA);

   uart_loader_asm u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (restart_i),
      .byte_valid_i (asm_valid),
      .len_phase_i  (state_q == S_LEN),
      .byte_i       (rx_data_i),
      .word_ready_o (word_ready),
      .word_o       (word),
      .csum_o       (csum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_LEN;
         len_q        <= '0;
         word_cnt_q   <= '0;
         rx_ack_q     <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= BASE;
         imem_wdata_q <= 32'd0;
         load_busy_q  <= 1'b1;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
         cpu_rst_n_q  <= 1'b0;
      end else begin
         rx_ack_q  <= rx_valid_i;
         imem_we_q <= 1'b0;
         if (restart_i) begin
            state_q     <= S_LEN;
            len_q       <= '0;
            word_cnt_q  <= '0;
            imem_addr_q <= BASE;
            load_busy_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
         end else if (rx_valid_i) begin
            case (state_q)
               S_LEN: begin
                  if (word_ready) begin
                     if (word > MAX_WORDS) begin
                        state_q     <= S_ERR;
                        load_busy_q <= 1'b0;
                        load_err_q  <= 1'b1;
                     end else begin
                        len_q   <= word[CNT_W-1:0];
                        state_q <= (word == 32'd0) ? S_SUM : S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (word_ready) begin
                     imem_we_q    <= 1'b1;
                     imem_wdata_q <= word;
                     imem_addr_q  <= BASE + word_cnt_q[ADDR_W-1:0];
                     word_cnt_q   <= word_cnt_q + CNT_W'(1);
                     if (word_cnt_q + CNT_W'(1) == len_q) begin
                        state_q <= S_SUM;
                     end
                  end
               end
               S_SUM: begin
                  load_busy_q <= 1'b0;
                  if (rx_data_i == csum) begin
                     state_q     <= S_DONE;
                     load_done_q <= 1'b1;
                     cpu_rst_n_q <= 1'b1;
                  end else begin
                     state_q    <= S_ERR;
                     load_err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ack_o     = rx_ack_q;
   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;
   assign load_busy_o  = load_busy_q;
   assign load_done_o  = load_done_q;
   assign load_err_o   = load_err_q;
   assign cpu_rst_n_o  = cpu_rst_n_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: frame table plus hand-written restart,
// async-reset and back-to-back sequences; imem writes checked by scoreboard.
module tb_uart_loader;

   localparam int ADDR_W    = 14;
   localparam int MAX_WORDS = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data_i = 8'd0;
   logic              rx_valid_i = 1'b0;
   logic              rx_ack_o;
   logic              restart_i = 1'b0;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o;
   logic              load_busy_o;
   logic              load_done_o;
   logic              load_err_o;
   logic              cpu_rst_n_o;

   uart_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data_i    (rx_data_i),
      .rx_valid_i   (rx_valid_i),
      .rx_ack_o     (rx_ack_o),
      .restart_i    (restart_i),
      .imem_we_o    (imem_we_o),
      .imem_addr_o  (imem_addr_o),
      .imem_wdata_o (imem_wdata_o),
      .load_busy_o  (load_busy_o),
      .load_done_o  (load_done_o),
      .load_err_o   (load_err_o),
      .cpu_rst_n_o  (cpu_rst_n_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct {
      logic [31:0] len;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  csum_delta;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   wr_t        sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] csum_m = 8'd0;
   logic       prev_v = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard pop on every write; rx_ack must follow every rx_valid by one cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_v || rx_ack_o) check("rx_ack", rx_ack_o, prev_v);
         prev_v = rx_valid_i;
         if (imem_we_o) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                        imem_addr_o, imem_wdata_o);
            end else begin
               wr_t e;
               e = sb.pop_front();
               check("wr_addr", imem_addr_o, e.addr);
               check("wr_data", imem_wdata_o, e.data);
               $display("write addr 0x%0h data 0x%08h", imem_addr_o, imem_wdata_o);
            end
         end
      end else begin
         prev_v = 1'b0;
      end
   end

   // All tasks start and end at posedge+1.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      @(posedge clk); #1;
      rx_valid_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_counted(input logic [7:0] b, input int gap);
      csum_m = csum_m + b;
      send_byte(b, gap);
   endtask

   task automatic send_word(input logic [31:0] w, input int idx, input int gap);
      wr_t e;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            e.addr = ADDR_W'(idx);
            e.data = w;
            sb.push_back(e);
         end
         send_counted(w[8*k +: 8], gap);
      end
   endtask

   task automatic send_len(input logic [31:0] len, input int gap);
      csum_m = 8'd0;
      for (int k = 0; k < 4; k++) send_counted(len[8*k +: 8], gap);
   endtask

   task automatic do_restart();
      restart_i = 1'b1;
      @(posedge clk); #1;
      restart_i = 1'b0;
      csum_m = 8'd0;
   endtask

   task automatic drain_and_check_status(input string tag, input logic done, input logic err);
      for (int i = 0; i < 6 && sb.size() != 0; i++) begin @(posedge clk); #1; end
      repeat (2) begin @(posedge clk); #1; end
      check({tag, "_pending_writes"}, sb.size(), 0);
      check({tag, "_done"}, load_done_o, done);
      check({tag, "_err"}, load_err_o, err);
      check({tag, "_cpu_rst_n"}, cpu_rst_n_o, done);
      check({tag, "_busy"}, load_busy_o, 1'b0);
      $display("%s: done=%0b err=%0b cpu_rst_n=%0b", tag, load_done_o, load_err_o, cpu_rst_n_o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      vec_t vecs[5];
      vecs[0] = '{32'd2, 32'h11223344, 32'hAABBCCDD, 8'd0, 1'b1, 1'b0};
      vecs[1] = '{32'd2, 32'h11223344, 32'hAABBCCDD, 8'd1, 1'b0, 1'b1};
      vecs[2] = '{32'd0, 32'h0,        32'h0,        8'd0, 1'b1, 1'b0};
      vecs[3] = '{32'(MAX_WORDS + 1), 32'h0, 32'h0,  8'd0, 1'b0, 1'b1};
      vecs[4] = '{32'd1, 32'hDEADBEEF, 32'h0,        8'd0, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", load_busy_o, 1'b1);
      check("rst_cpu_rst_n", cpu_rst_n_o, 1'b0);
      check("rst_we", imem_we_o, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_done", load_done_o, 1'b0);
      check("rst_err", load_err_o, 1'b0);
      check("rst_addr", imem_addr_o, 0);
      check("rst_ack", rx_ack_o, 1'b0);
      $display("reset: busy=%0b cpu_rst_n=%0b", load_busy_o, cpu_rst_n_o);

      for (int v = 0; v < 5; v++) begin
         do_restart();
         check("restart_busy", load_busy_o, 1'b1);
         check("restart_done", load_done_o, 1'b0);
         check("restart_err", load_err_o, 1'b0);
         check("restart_cpu_rst_n", cpu_rst_n_o, 1'b0);
         send_len(vecs[v].len, 2);
         if (vecs[v].len > 32'(MAX_WORDS)) begin
            check("ovf_err_immediate", load_err_o, 1'b1);
            for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 1);
         end else begin
            if (vecs[v].len > 0) send_word(vecs[v].w0, 0, 2);
            if (vecs[v].len > 1) send_word(vecs[v].w1, 1, 2);
            send_byte(csum_m + vecs[v].csum_delta, 2);
         end
         drain_and_check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      end

      // Restart mid-word, with a byte arriving in the restart cycle
      do_restart();
      send_len(32'd2, 1);
      send_counted(8'h77, 1);
      send_counted(8'h66, 1);
      restart_i  = 1'b1;
      rx_data_i  = 8'h55;
      rx_valid_i = 1'b1;
      @(posedge clk); #1;
      restart_i  = 1'b0;
      rx_valid_i = 1'b0;
      @(posedge clk); #1;
      check("midword_restart_busy", load_busy_o, 1'b1);
      send_len(32'd2, 1);
      send_word(32'hCAFEF00D, 0, 1);
      send_word(32'h01020304, 1, 1);
      send_byte(csum_m, 1);
      drain_and_check_status("restart_seq", 1'b1, 1'b0);

      // Asynchronous reset during S_DATA
      do_restart();
      send_len(32'd1, 1);
      send_counted(8'h12, 1);
      send_counted(8'h34, 1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", load_busy_o, 1'b1);
      check("arst_cpu_rst_n", cpu_rst_n_o, 1'b0);
      check("arst_done", load_done_o, 1'b0);
      check("arst_we", imem_we_o, 1'b0);
      check("arst_addr", imem_addr_o, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_len(32'd1, 1);
      send_word(32'h89ABCDEF, 0, 1);
      send_byte(csum_m, 1);
      drain_and_check_status("arst_seq", 1'b1, 1'b0);

      // Back-to-back valids on every byte
      do_restart();
      send_len(32'd2, 0);
      send_word(32'h0BADF00D, 0, 0);
      send_word(32'h13579BDF, 1, 0);
      send_byte(csum_m, 0);
      drain_and_check_status("b2b_seq", 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
